uart_rx_sampler: RTL and testbench

//  Front end of the UART receiver. Synchronises the raw rx line and runs an OVERSAMPLE-x baud tick.

---
 rtl/uart_pkg.sv | 8 +
 rtl/uart_baud_tick_gen.sv | 18 +
 rtl/uart_rx_sampler.sv | 99 +++++++++
 tb/tb_uart_rx_sampler.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared state type, default oversample factor and baud divider helper for the UART receiver
package uart_pkg;
  typedef enum logic [1:0] {S_IDLE, S_START, S_RUN} t_rx_sampler_states;
  localparam int OVERSAMPLE_DEF = 16;
  function automatic int calc_div(input int clk_hz, input int baud, input int os);
    return clk_hz / (baud * os);
  endfunction
endpackage

// File: rtl/uart_baud_tick_gen.sv
// uart_baud_tick_gen: one-cycle os tick every DIV clocks, phase reset by a synchronous clear
module uart_baud_tick_gen #(
  parameter int DIV = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic tick_o
);
  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  logic [W-1:0] r_cnt;
  logic w_wrap;
  assign w_wrap = r_cnt == W'(DIV - 1);
  assign tick_o = !clr_i && w_wrap;
  always_ff @(posedge clk_i)
    if (rst_i || clr_i || w_wrap) r_cnt <= '0;
    else r_cnt <= r_cnt + W'(1);
endmodule

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: synchronises rx, validates start bits, majority-votes bit centres and flags line breaks
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int BAUD_RATE   = 115_200,
  parameter int OVERSAMPLE  = OVERSAMPLE_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int BREAK_BITS  = 10
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic rx_i,
  input  logic is_rx_idle_i,
  output logic trigger_o,
  output logic sampled_start_o,
  output logic rx_bit_o,
  output logic start_glitch_o,
  output logic break_o
);
  localparam int DIV = calc_div(CLK_FREQ_HZ, BAUD_RATE, OVERSAMPLE);
  localparam int H = OVERSAMPLE / 2;
  localparam int BRK = BREAK_BITS * OVERSAMPLE;
  localparam int OW = $clog2(OVERSAMPLE + 1);
  localparam int BW = $clog2(BRK + 1);
  if (DIV < 2 || OVERSAMPLE < 8 || OVERSAMPLE % 2 != 0 || SYNC_STAGES < 2) begin : g_param_check
    $error("uart_rx_sampler: invalid parameters");
  end
  t_rx_sampler_states r_state, w_state_nx;
  logic [SYNC_STAGES-1:0] r_sync, r_vld;
  logic [OW-1:0] r_os, w_os_nx, w_n;
  logic [BW-1:0] r_brk, w_brk_nx;
  logic [1:0] r_smp, w_smp_nx;
  logic r_rx_d, r_armed, w_armed_nx;
  logic r_trig, r_sstart, r_bit, r_glitch, r_break;
  logic w_rx, w_rx_ok, w_fall, w_tick, w_start, w_in_start, w_smp, w_dec, w_maj, w_quit;
  assign w_rx = r_sync[SYNC_STAGES-1];
  assign w_rx_ok = w_rx && r_vld[SYNC_STAGES-1];
  assign w_fall = r_rx_d && !w_rx;
  assign w_start = r_state == S_IDLE && r_armed && is_rx_idle_i && w_fall;
  uart_baud_tick_gen #(.DIV(DIV)) u_tick (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .clr_i(w_start),
    .tick_o(w_tick)
  );
  always_comb begin
    w_in_start = r_state == S_START;
    w_n = r_os + OW'(1);
    w_smp = w_tick && (w_in_start ? (w_n >= OW'(H - 1) && w_n <= OW'(H + 1))
                                  : (r_state == S_RUN && w_n >= OW'(OVERSAMPLE - 2)));
    w_dec = w_tick && (w_in_start ? w_n == OW'(H + 1) : (r_state == S_RUN && w_n == OW'(OVERSAMPLE)));
    w_maj = (r_smp[1] && r_smp[0]) || ((r_smp[1] || r_smp[0]) && w_rx);
    w_quit = r_state == S_RUN && !r_trig && is_rx_idle_i;
    w_state_nx = w_start ? S_START
               : w_quit ? S_IDLE
               : (w_dec && w_in_start) ? (w_maj ? S_IDLE : S_RUN)
               : r_state;
    w_armed_nx = w_rx_ok || (r_state == S_IDLE && r_armed);
    w_os_nx = (r_state == S_IDLE || w_dec) ? '0 : w_tick ? w_n : r_os;
    w_smp_nx = w_smp ? {r_smp[0], w_rx} : r_smp;
    w_brk_nx = w_rx ? '0 : (w_tick && r_brk != BW'(BRK)) ? r_brk + BW'(1) : r_brk;
  end
  always_ff @(posedge clk_i)
    if (rst_i) begin
      r_sync <= '1;
      r_vld <= '0;
      r_rx_d <= 1'b1;
      r_state <= S_IDLE;
      r_armed <= 1'b0;
      r_os <= '0;
      r_smp <= '1;
      r_brk <= '0;
      r_trig <= 1'b0;
      r_sstart <= 1'b0;
      r_bit <= 1'b1;
      r_glitch <= 1'b0;
      r_break <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], rx_i};
      r_vld <= {r_vld[SYNC_STAGES-2:0], 1'b1};
      r_rx_d <= w_rx;
      r_state <= w_state_nx;
      r_armed <= w_armed_nx;
      r_os <= w_os_nx;
      r_smp <= w_smp_nx;
      r_brk <= w_brk_nx;
      r_trig <= w_dec && !w_quit && !(w_in_start && w_maj);
      r_sstart <= w_dec && w_in_start && !w_maj;
      r_bit <= w_dec ? w_maj : r_bit;
      r_glitch <= w_dec && w_in_start && w_maj;
      r_break <= !w_rx && w_brk_nx == BW'(BRK);
    end
  assign trigger_o = r_trig;
  assign sampled_start_o = r_sstart;
  assign rx_bit_o = r_bit;
  assign start_glitch_o = r_glitch;
  assign break_o = r_break;
endmodule

// File: tb/tb_uart_rx_sampler.sv
// tb_uart_rx_sampler: randomized frame-level checks of the rx sampler against a bit-period reference model
module tb_uart_rx_sampler;
  localparam int BIT = 32;
  localparam int SYNC = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx = 1'b0;
  logic idle = 1'b1;
  logic trig, sstart, rbit, glitch, brk;
  logic prev_trig = 1'b0;
  logic prev_brk = 1'b0;
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int ctl_n = 0;
  int n_glitch = 0;
  int brk_rise = -1;
  int brk_fall = -1;
  int q_cyc[$];
  logic q_st[$];
  logic q_bit[$];
  always #5 clk = ~clk;
  uart_rx_sampler #(
    .CLK_FREQ_HZ(3_686_400),
    .BAUD_RATE(115_200),
    .OVERSAMPLE(16),
    .SYNC_STAGES(SYNC),
    .BREAK_BITS(10)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .rx_i(rx),
    .is_rx_idle_i(idle),
    .trigger_o(trig),
    .sampled_start_o(sstart),
    .rx_bit_o(rbit),
    .start_glitch_o(glitch),
    .break_o(brk)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      idle <= 1'b1;
      ctl_n <= 0;
    end else if (trig) begin
      idle <= ctl_n == 10;
      ctl_n <= ctl_n == 10 ? 0 : ctl_n + 1;
    end
  end
  always @(negedge clk) begin
    if (trig) begin
      check("trig_with_glitch", glitch, 1'b0);
      check("trig_back_to_back", prev_trig, 1'b0);
      q_cyc.push_back(cyc);
      q_st.push_back(sstart);
      q_bit.push_back(rbit);
    end
    if (glitch) n_glitch <= n_glitch + 1;
    if (brk && !prev_brk) brk_rise <= cyc;
    if (!brk && prev_brk) brk_fall <= cyc;
    prev_trig <= trig;
    prev_brk <= brk;
  end
  function automatic logic [10:0] mk_frame(input logic [7:0] d);
    return {1'b1, ^d, d, 1'b0};
  endfunction
  task automatic clear_q();
    q_cyc.delete();
    q_st.delete();
    q_bit.delete();
  endtask
  task automatic drive_frame(input logic [10:0] f, input int nb);
    for (int j = 0; j < 11; j++) begin
      rx = f[j];
      if (j == nb) begin
        repeat (BIT / 2) @(negedge clk);
        rx = ~f[j];
        repeat (2) @(negedge clk);
        rx = f[j];
        repeat (BIT / 2 - 2) @(negedge clk);
      end else repeat (BIT) @(negedge clk);
    end
    rx = 1'b1;
  endtask
  task automatic run_frame(input logic [7:0] d, input int nb);
    logic [10:0] f;
    int k, lat;
    f = mk_frame(d);
    clear_q();
    k = cyc;
    drive_frame(f, nb);
    repeat (4 + $urandom_range(0, 30)) @(negedge clk);
    check("frame_triggers", q_cyc.size(), 11);
    for (int j = 0; j < 11 && j < q_cyc.size(); j++) begin
      check($sformatf("frame_%02h_bit%0d", d, j), q_bit[j], f[j]);
      check($sformatf("frame_%02h_start_flag%0d", d, j), q_st[j], j == 0);
      if (j == 0) begin
        lat = q_cyc[0] - k;
        check("start_latency_window", lat >= 19 && lat <= 24, 1'b1);
      end else check("trigger_spacing", q_cyc[j] - q_cyc[j-1], BIT);
    end
  endtask
  task automatic check_reset_outs(input string tag);
    check({tag, "_trigger"}, trig, 1'b0);
    check({tag, "_sampled_start"}, sstart, 1'b0);
    check({tag, "_rx_bit"}, rbit, 1'b1);
    check({tag, "_glitch"}, glitch, 1'b0);
    check({tag, "_break"}, brk, 1'b0);
  endtask
  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
  initial begin
    int g0, k, h;
    repeat (2) @(negedge clk);
    check_reset_outs("reset");
    rst = 1'b0;
    repeat (100) @(negedge clk);
    check("low_after_reset_triggers", q_cyc.size(), 0);
    check("low_after_reset_glitches", n_glitch, 0);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    run_frame(8'hA5, -1);
    g0 = n_glitch;
    clear_q();
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_pulses", n_glitch - g0, 1);
    check("glitch_triggers", q_cyc.size(), 0);
    run_frame(8'($urandom_range(0, 255)), -1);
    for (int i = 0; i < 6; i++)
      run_frame(8'($urandom_range(0, 255)), $urandom_range(0, 1) ? int'($urandom_range(1, 8)) : -1);
    clear_q();
    brk_rise = -1;
    brk_fall = -1;
    k = cyc;
    rx = 1'b0;
    repeat (300) @(negedge clk);
    check("break_not_early", brk, 1'b0);
    repeat (100) @(negedge clk);
    check("break_rise_window", brk_rise - k >= 320 && brk_rise - k <= 320 + SYNC + 4, 1'b1);
    check("break_high", brk, 1'b1);
    h = cyc;
    rx = 1'b1;
    repeat (10) @(negedge clk);
    check("break_fall_window", brk_fall - h >= 1 && brk_fall - h <= SYNC + 2, 1'b1);
    check("break_frame_triggers", q_cyc.size(), 11);
    repeat (40) @(negedge clk);
    check("no_false_start_after_break", q_cyc.size(), 11);
    run_frame(8'($urandom_range(0, 255)), -1);
    clear_q();
    fork
      drive_frame(mk_frame(8'h01), -1);
      begin
        for (int t = 0; t < 200 && q_cyc.size() < 3; t++) @(negedge clk);
        check("triggers_before_reset", q_cyc.size(), 3);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outs("mid_frame_reset");
        rst = 1'b0;
      end
    join
    repeat (40) @(negedge clk);
    check("no_triggers_after_reset", q_cyc.size(), 3);
    run_frame(8'($urandom_range(0, 255)), -1);
    run_frame(8'($urandom_range(0, 255)), int'($urandom_range(1, 8)));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
